// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - request/response load/store unit with byte-lane steering
// Optional: define LOAD_STORE_MISALIGNED_EN to split word-crossing accesses into two beats.
module load_store_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = XLEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_address,
  input  logic [XLEN-1:0]     req_store_value,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_efault,
  output logic [XLEN-1:0]     rsp_load_value,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_we,
  output logic [XLEN/8-1:0]   mem_wmask,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int NB  = XLEN / 8;
  localparam int LW  = $clog2(NB);
  localparam int NB2 = 2 * NB;
  localparam logic [2:0] LW3 = 3'(LW);

`ifdef LOAD_STORE_MISALIGNED_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_WAIT0, S_BEAT1, S_WAIT1, S_RESP} state_t;

  state_t              r_state;
  logic                r_store;
  logic [2:0]          r_funct3;
  logic [LW-1:0]       r_off;
  logic [ADDR_W-1:0]   r_base;
  logic                r_split;
  logic [XLEN-1:0]     r_data0;
  logic [NB-1:0]       r_hi_mask;
  logic [XLEN-1:0]     r_hi_wdata;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic                r_rsp_efault;
  logic [XLEN-1:0]     r_rsp_load_value;
  logic                r_mem_req_valid;
  logic [ADDR_W-1:0]   r_mem_address;
  logic                r_mem_we;
  logic [NB-1:0]       r_mem_wmask;
  logic [XLEN-1:0]     r_mem_wdata;

  logic [1:0]          w_size_log;
  logic [LW-1:0]       w_off;
  logic [3:0]          w_size_bytes;
  logic                w_fits;
  logic                w_legal;
  logic                w_misal;
  logic [4:0]          w_end;
  logic                w_split;
  logic                w_fault;
  logic [NB2-1:0]      w_mask2;
  logic [2*XLEN-1:0]   w_wdata2;

  // Mask and data are built two words wide so a crossing access spills into the upper half.
  always_comb begin
    w_size_log   = req_funct3[1:0];
    w_off        = req_address[LW-1:0];
    w_size_bytes = 4'd1 << w_size_log;
    w_fits       = {1'b0, w_size_log} <= LW3;
    if (req_store) w_legal = !req_funct3[2] && w_fits;
    else           w_legal = w_fits && (!req_funct3[2] || ({1'b0, w_size_log} < LW3));
    w_misal  = (w_off & LW'(w_size_bytes - 4'd1)) != '0;
    w_end    = 5'(w_off) + {1'b0, w_size_bytes};
    w_split  = w_end > 5'(NB);
    w_fault  = !w_legal || (w_misal && !MIS_EN);
    w_mask2  = ((NB2'(1) << w_size_bytes) - NB2'(1)) << w_off;
    w_wdata2 = {{XLEN{1'b0}}, req_store_value} << {w_off, 3'b000};
  end

  function automatic logic [XLEN-1:0] f_extract(input logic [2*XLEN-1:0] d,
                                                input logic [LW-1:0] off,
                                                input logic [2:0] f3);
    logic [2*XLEN-1:0] s;
    logic [XLEN-1:0]   x;
    logic [XLEN-1:0]   m;
    logic              sgn;
    s = d >> {off, 3'b000};
    x = s[XLEN-1:0];
    case (f3[1:0])
      2'd0:    begin m = XLEN'(8'hff);         sgn = x[7];  end
      2'd1:    begin m = XLEN'(16'hffff);      sgn = x[15]; end
      2'd2:    begin m = XLEN'(32'hffff_ffff); sgn = x[31]; end
      default: begin m = '1;                   sgn = 1'b0;  end
    endcase
    return (x & m) | ((sgn && !f3[2]) ? ~m : '0);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_store          <= 1'b0;
      r_funct3         <= '0;
      r_off            <= '0;
      r_base           <= '0;
      r_split          <= 1'b0;
      r_data0          <= '0;
      r_hi_mask        <= '0;
      r_hi_wdata       <= '0;
      r_req_ready      <= 1'b1;
      r_rsp_valid      <= 1'b0;
      r_rsp_efault     <= 1'b0;
      r_rsp_load_value <= '0;
      r_mem_req_valid  <= 1'b0;
      r_mem_address    <= '0;
      r_mem_we         <= 1'b0;
      r_mem_wmask      <= '0;
      r_mem_wdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_store     <= req_store;
            r_funct3    <= req_funct3;
            r_off       <= w_off;
            r_base      <= {req_address[ADDR_W-1:LW], {LW{1'b0}}};
            r_split     <= w_split && !w_fault;
            r_hi_mask   <= w_mask2[NB2-1:NB];
            r_hi_wdata  <= w_wdata2[2*XLEN-1:XLEN];
            r_req_ready <= 1'b0;
            if (w_fault) begin
              r_state          <= S_RESP;
              r_rsp_valid      <= 1'b1;
              r_rsp_efault     <= 1'b1;
              r_rsp_load_value <= '0;
            end else begin
              r_state         <= S_BEAT0;
              r_mem_req_valid <= 1'b1;
              r_mem_address   <= {req_address[ADDR_W-1:LW], {LW{1'b0}}};
              r_mem_we        <= req_store;
              r_mem_wmask     <= req_store ? w_mask2[NB-1:0] : '0;
              r_mem_wdata     <= req_store ? w_wdata2[XLEN-1:0] : '0;
            end
          end
        end
        S_BEAT0, S_BEAT1: begin
          if (mem_req_ready) begin
            if (r_store && r_split && r_state == S_BEAT0) begin
              r_state       <= S_BEAT1;
              r_mem_address <= r_base + ADDR_W'(NB);
              r_mem_wmask   <= r_hi_mask;
              r_mem_wdata   <= r_hi_wdata;
            end else begin
              r_mem_req_valid <= 1'b0;
              r_mem_address   <= '0;
              r_mem_we        <= 1'b0;
              r_mem_wmask     <= '0;
              r_mem_wdata     <= '0;
              if (r_store) begin
                r_state          <= S_RESP;
                r_rsp_valid      <= 1'b1;
                r_rsp_efault     <= 1'b0;
                r_rsp_load_value <= '0;
              end else begin
                r_state <= (r_state == S_BEAT0) ? S_WAIT0 : S_WAIT1;
              end
            end
          end
        end
        S_WAIT0: begin
          if (mem_rvalid) begin
            r_data0 <= mem_rdata;
            if (r_split) begin
              r_state         <= S_BEAT1;
              r_mem_req_valid <= 1'b1;
              r_mem_address   <= r_base + ADDR_W'(NB);
            end else begin
              r_state          <= S_RESP;
              r_rsp_valid      <= 1'b1;
              r_rsp_efault     <= 1'b0;
              r_rsp_load_value <= f_extract({{XLEN{1'b0}}, mem_rdata}, r_off, r_funct3);
            end
          end
        end
        S_WAIT1: begin
          if (mem_rvalid) begin
            r_state          <= S_RESP;
            r_rsp_valid      <= 1'b1;
            r_rsp_efault     <= 1'b0;
            r_rsp_load_value <= f_extract({mem_rdata, r_data0}, r_off, r_funct3);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state          <= S_IDLE;
            r_rsp_valid      <= 1'b0;
            r_rsp_efault     <= 1'b0;
            r_rsp_load_value <= '0;
            r_req_ready      <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_efault     = r_rsp_efault;
  assign rsp_load_value = r_rsp_load_value;
  assign mem_req_valid  = r_mem_req_valid;
  assign mem_address    = r_mem_address;
  assign mem_we         = r_mem_we;
  assign mem_wmask      = r_mem_wmask;
  assign mem_wdata      = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit (XLEN=32)
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_address = '0, req_store_value = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_efault;
  logic [31:0] rsp_load_value;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_address(req_address), .req_store_value(req_store_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_efault(rsp_efault),
    .rsp_load_value(rsp_load_value),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_address(mem_address),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {logic ef; logic [31:0] val; int lat;} rsp_t;
  typedef struct {logic [31:0] addr; logic we; logic [3:0] mask; logic [31:0] wdata;} beat_t;

  rsp_t        rsp_q[$];
  beat_t       beat_q[$];
  logic [31:0] rd_q[$];
  int n_vec = 0, n_fail = 0, cyc = 0, acc_cyc = 0, n_beats = 0, n_rsps = 0, stall = 0;
  logic hold = 1'b0, stray = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  task automatic push_rsp(input logic ef, input logic [31:0] val, input int lat);
    rsp_t r;
    r.ef = ef; r.val = val; r.lat = lat;
    rsp_q.push_back(r);
  endtask

  task automatic push_beat(input logic [31:0] a, input logic we, input logic [3:0] m, input logic [31:0] d);
    beat_t b;
    b.addr = a; b.we = we; b.mask = m; b.wdata = d;
    beat_q.push_back(b);
  endtask

  // memory model: one-cycle read latency, programmable request stall
  initial begin
    logic        pend;
    logic [31:0] data;
    mem_req_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      pend = mem_req_valid && mem_req_ready && !mem_we && !hold && rst_n;
      data = 32'h0;
      if (pend) data = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hdeadbeef;
      @(posedge clk); #1;
      mem_rvalid = pend || stray;
      mem_rdata  = pend ? data : (stray ? 32'hffffffff : 32'h0);
      stray = 1'b0;
      mem_req_ready = (stall == 0);
      if (mem_req_valid && stall > 0) stall--;
    end
  end

  // beat monitor
  initial begin
    logic        held = 1'b0;
    logic [40:0] snap = '0;
    beat_t       b;
    forever begin
      @(negedge clk);
      if (held && mem_req_valid) chk("beat_stable", {23'b0, mem_address, mem_we, mem_wmask, mem_wdata[31:28]}, {23'b0, snap});
      held = 1'b0;
      if (mem_req_valid && mem_req_ready) begin
        n_beats++;
        if (beat_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL beat_unexpected: got addr %h we %b expected no beat", mem_address, mem_we);
        end else begin
          b = beat_q.pop_front();
          chk("beat_addr", {32'b0, mem_address}, {32'b0, b.addr});
          chk("beat_we_mask", {59'b0, mem_we, mem_wmask}, {59'b0, b.we, b.mask});
          chk("beat_wdata", {32'b0, mem_wdata & bmask(b.mask)}, {32'b0, b.wdata & bmask(b.mask)});
        end
      end else if (mem_req_valid) begin
        held = 1'b1;
        snap = {mem_address, mem_we, mem_wmask, mem_wdata[31:28]};
      end
    end
  end

  // response monitor
  initial begin
    logic        held = 1'b0, seen = 1'b0;
    logic [32:0] snap = '0;
    rsp_t        r;
    forever begin
      @(negedge clk);
      if (rsp_valid) chk("rsp_req_exclusive", {63'b0, req_ready}, 64'd0);
      if (held) chk("rsp_stable", {31'b0, rsp_valid, rsp_efault, rsp_load_value}, {31'b0, 1'b1, snap});
      if (rsp_valid && !seen && rsp_q.size() > 0 && rsp_q[0].lat > 0)
        chk("rsp_latency", 64'(cyc - acc_cyc + 1), 64'(rsp_q[0].lat));
      seen = rsp_valid;
      held = 1'b0;
      if (rsp_valid && rsp_ready) begin
        n_rsps++;
        if (rsp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL rsp_unexpected: got efault %b value %h expected no response", rsp_efault, rsp_load_value);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_efault", {63'b0, rsp_efault}, {63'b0, r.ef});
          chk("rsp_value", {32'b0, rsp_load_value}, {32'b0, r.val});
        end
      end else if (rsp_valid) begin
        held = 1'b1;
        snap = {rsp_efault, rsp_load_value};
      end
    end
  end

  // called #1 after a rising edge; returns #1 after the accepting edge
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] v);
    bit ok = 1'b0;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_address = a; req_store_value = v;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("req_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {59'b0, req_ready, rsp_valid, mem_req_valid, rsp_efault, mem_we}, {59'b0, 5'b10000});
    chk({tag, "_addr_mask"}, {28'b0, mem_address, mem_wmask}, 64'd0);
    chk({tag, "_data"}, {mem_wdata, rsp_load_value}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, r0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // aligned loads with extension
    rd_q.push_back(32'h456789ab); push_beat(32'h0, 1'b0, 4'h0, 32'h0); push_rsp(1'b0, 32'hffffff89, 3);
    issue(1'b0, 3'b000, 32'h1, 32'h0); wait_done();
    rd_q.push_back(32'h456789ab); push_beat(32'h0, 1'b0, 4'h0, 32'h0); push_rsp(1'b0, 32'h00000089, 3);
    issue(1'b0, 3'b100, 32'h1, 32'h0); wait_done();
    rd_q.push_back(32'h80017f00); push_beat(32'h0, 1'b0, 4'h0, 32'h0); push_rsp(1'b0, 32'hffff8001, 3);
    issue(1'b0, 3'b001, 32'h2, 32'h0); wait_done();
    rd_q.push_back(32'h80017f00); push_beat(32'h0, 1'b0, 4'h0, 32'h0); push_rsp(1'b0, 32'h00008001, 3);
    issue(1'b0, 3'b101, 32'h2, 32'h0); wait_done();
    rd_q.push_back(32'hdeadbeef); push_beat(32'h4, 1'b0, 4'h0, 32'h0); push_rsp(1'b0, 32'hdeadbeef, 3);
    issue(1'b0, 3'b010, 32'h4, 32'h0); wait_done();
    rd_q.push_back(32'h7f000000); push_beat(32'h0, 1'b0, 4'h0, 32'h0); push_rsp(1'b0, 32'h0000007f, 3);
    issue(1'b0, 3'b000, 32'h3, 32'h0); wait_done();

    // aligned stores
    push_beat(32'h0, 1'b1, 4'b1100, 32'h12340000); push_rsp(1'b0, 32'h0, 2);
    issue(1'b1, 3'b001, 32'h2, 32'h00001234); wait_done();
    push_beat(32'h4, 1'b1, 4'b1000, 32'ha5000000); push_rsp(1'b0, 32'h0, 2);
    issue(1'b1, 3'b000, 32'h7, 32'h000000a5); wait_done();
    push_beat(32'h8, 1'b1, 4'b1111, 32'hcafef00d); push_rsp(1'b0, 32'h0, 2);
    issue(1'b1, 3'b010, 32'h8, 32'hcafef00d); wait_done();

    // illegal encodings fault without memory traffic
    push_rsp(1'b1, 32'h0, 1); issue(1'b0, 3'b011, 32'h0, 32'h0); wait_done();
    push_rsp(1'b1, 32'h0, 1); issue(1'b0, 3'b110, 32'h0, 32'h0); wait_done();
    push_rsp(1'b1, 32'h0, 1); issue(1'b1, 3'b100, 32'h0, 32'h0); wait_done();

`ifdef LOAD_STORE_MISALIGNED_EN
    rd_q.push_back(32'h456789ab); rd_q.push_back(32'hcdef0123);
    push_beat(32'h0, 1'b0, 4'h0, 32'h0); push_beat(32'h4, 1'b0, 4'h0, 32'h0);
    push_rsp(1'b0, 32'h01234567, 5);
    issue(1'b0, 3'b010, 32'h2, 32'h0); wait_done();
    rd_q.push_back(32'h456789ab); push_beat(32'h0, 1'b0, 4'h0, 32'h0); push_rsp(1'b0, 32'h00006789, 3);
    issue(1'b0, 3'b001, 32'h1, 32'h0); wait_done();
    push_beat(32'h0, 1'b1, 4'b1000, 32'hef000000); push_beat(32'h4, 1'b1, 4'b0001, 32'h000000be);
    push_rsp(1'b0, 32'h0, 3);
    issue(1'b1, 3'b001, 32'h3, 32'h0000beef); wait_done();
`else
    push_rsp(1'b1, 32'h0, 1); issue(1'b0, 3'b010, 32'h2, 32'h0); wait_done();
    push_rsp(1'b1, 32'h0, 1); issue(1'b0, 3'b001, 32'h1, 32'h0); wait_done();
    push_rsp(1'b1, 32'h0, 1); issue(1'b1, 3'b001, 32'h3, 32'h0000beef); wait_done();
`endif

    // backpressure on both sides
    b0 = n_beats; r0 = n_rsps;
    stall = 3; rsp_ready = 1'b0;
    rd_q.push_back(32'h13579bdf); push_beat(32'h10, 1'b0, 4'h0, 32'h0); push_rsp(1'b0, 32'h13579bdf, 0);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_done();
    chk("stall_one_beat", 64'(n_beats - b0), 64'd1);
    chk("stall_one_rsp", 64'(n_rsps - r0), 64'd1);

    // reset while waiting for read data, then a stray rvalid
    hold = 1'b1;
    r0 = n_rsps;
    push_beat(32'h20, 1'b0, 4'h0, 32'h0);
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold = 1'b0;
    stray = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_idle", {62'b0, rsp_valid, req_ready}, {62'b0, 2'b01});
    chk("post_reset_no_rsp", 64'(n_rsps - r0), 64'd0);

    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    chk("beat_queue_drained", 64'(beat_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
